ser_rx: RTL and testbench

SER_RX -- requirements
Module: ser_rx

---
 rtl/ser_rx.sv | 153 +++++++++++++++
 tb/tb_ser_rx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ser_rx.sv
// ser_rx -- serial frame receiver
//
// Receives frames of the form start(0), WIDTH data bits, optional even
// parity bit, stop(1). The line is sampled only on clk edges where bit_en
// is high, so bit_en sets the bit rate. Bit order is taken from dir when
// the start bit is seen and held for the whole frame.
//
// Optional feature: define SER_RX_PARITY_EN to add a parity bit after the
// data bits, checked as even parity over data plus parity bit.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   bit_en    in   bit strobe; ser_in is sampled only when high
//   ser_in    in   serial line, idle high
//   dir       in   1 = LSB first, 0 = MSB first
//   data      out  last good received word (held across errors)
//   valid     out  one-cycle pulse: new word on data
//   frame_err out  one-cycle pulse: bad stop bit or bad parity
//   busy      out  high whenever a frame is in progress
module ser_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             ser_in,
  input  logic             dir,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             stop_ok;

`ifdef SER_RX_PARITY_EN
  logic             par_err_q, par_err_d;
  // A frame is good only if the stop bit is high and parity matched.
  assign stop_ok = ser_in & ~par_err_q;
`else
  assign stop_ok = ser_in;
`endif

  // Next-state logic for the whole receiver; pulses default low so they
  // last exactly one cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    dir_d       = dir_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef SER_RX_PARITY_EN
    par_err_d   = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bit_en && !ser_in) begin
          state_d = DATA;
          cnt_d   = '0;
          shreg_d = '0;
          dir_d   = dir;
`ifdef SER_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      DATA: begin
        if (bit_en) begin
          // LSB first: new bit enters at the top so the first bit ends at bit 0.
          if (dir_q) shreg_d = {ser_in, shreg_q[WIDTH-1:1]};
          else       shreg_d = {shreg_q[WIDTH-2:0], ser_in};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
`ifdef SER_RX_PARITY_EN
            state_d = PAR;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef SER_RX_PARITY_EN
      PAR: begin
        if (bit_en) begin
          // Even parity: the parity bit must equal the XOR of the data bits.
          par_err_d = ser_in ^ (^shreg_q);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_en) begin
          state_d = IDLE;
          if (stop_ok) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All receiver state and registered outputs; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      dir_q       <= 1'b0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SER_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      dir_q       <= dir_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
`ifdef SER_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ser_rx.sv
module tb_ser_rx;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             bit_en;
  logic             ser_in;
  logic             dir;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             frame_err;
  logic             busy;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int overlap_cnt = 0;
  int v0;
  int f0;

`ifdef SER_RX_PARITY_EN
  logic bad_par = 1'b0;
`endif

  ser_rx #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .bit_en(bit_en),
    .ser_in(ser_in),
    .dir(dir),
    .data(data),
    .valid(valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Pulse monitor: samples the registered pulses just after each edge.
  always @(posedge clk) begin
    #1;
    if (valid) valid_cnt++;
    if (frame_err) ferr_cnt++;
    if (valid && frame_err) overlap_cnt++;
  end

  // Single comparison point; every check goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one line bit for a single bit_en cycle, then idles for gap-1 cycles.
  // Called and returns at a falling edge.
  task automatic sendBit(input logic b, input int gap);
    ser_in = b;
    bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    ser_in = 1'b1;
    repeat (gap - 1) @(negedge clk);
  endtask

  // Sends one frame; line[0] goes on the wire first. dir is flipped right
  // after the start bit to show it only matters at the start bit.
  task automatic applyStimulus(input logic [7:0] line, input logic d, input logic stop, input int gap);
    dir = d;
    sendBit(1'b0, gap);
    dir = ~d;
    for (int i = 0; i < 8; i++) sendBit(line[i], gap);
`ifdef SER_RX_PARITY_EN
    sendBit((^line) ^ bad_par, gap);
`endif
    sendBit(stop, gap);
    dir = d;
  endtask

  initial begin
    rst = 1'b1;
    bit_en = 1'b0;
    ser_in = 1'b1;
    dir = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_data", 32'(data), 32'h0);
    checkOutput("reset_valid", 32'(valid), 32'h0);
    checkOutput("reset_ferr", 32'(frame_err), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] LSB-first frame");
    v0 = valid_cnt; f0 = ferr_cnt;
    applyStimulus(8'h9A, 1'b1, 1'b1, 1);
    @(negedge clk);
    checkOutput("lsb_valid", 32'(valid_cnt - v0), 32'd1);
    checkOutput("lsb_ferr", 32'(ferr_cnt - f0), 32'd0);
    checkOutput("lsb_data", 32'(data), 32'h9A);
    checkOutput("lsb_busy", 32'(busy), 32'h0);

    $display("[TB] MSB-first frame");
    v0 = valid_cnt; f0 = ferr_cnt;
    applyStimulus(8'h9A, 1'b0, 1'b1, 1);
    @(negedge clk);
    checkOutput("msb_valid", 32'(valid_cnt - v0), 32'd1);
    checkOutput("msb_ferr", 32'(ferr_cnt - f0), 32'd0);
    checkOutput("msb_data", 32'(data), 32'h59);

    $display("[TB] bad stop bit");
    applyStimulus(8'h9A, 1'b1, 1'b1, 1);
    @(negedge clk);
    checkOutput("pre_bad_data", 32'(data), 32'h9A);
    v0 = valid_cnt; f0 = ferr_cnt;
    applyStimulus(8'h3C, 1'b1, 1'b0, 1);
    @(negedge clk);
    checkOutput("badstop_ferr", 32'(ferr_cnt - f0), 32'd1);
    checkOutput("badstop_valid", 32'(valid_cnt - v0), 32'd0);
    checkOutput("badstop_data", 32'(data), 32'h9A);

`ifdef SER_RX_PARITY_EN
    $display("[TB] parity");
    v0 = valid_cnt; f0 = ferr_cnt;
    bad_par = 1'b0;
    applyStimulus(8'h9A, 1'b1, 1'b1, 1);
    @(negedge clk);
    checkOutput("par_ok_valid", 32'(valid_cnt - v0), 32'd1);
    checkOutput("par_ok_data", 32'(data), 32'h9A);
    v0 = valid_cnt; f0 = ferr_cnt;
    bad_par = 1'b1;
    applyStimulus(8'h3C, 1'b1, 1'b1, 1);
    bad_par = 1'b0;
    @(negedge clk);
    checkOutput("par_bad_ferr", 32'(ferr_cnt - f0), 32'd1);
    checkOutput("par_bad_valid", 32'(valid_cnt - v0), 32'd0);
    checkOutput("par_bad_data", 32'(data), 32'h9A);
`endif

    $display("[TB] mid-frame reset");
    v0 = valid_cnt; f0 = ferr_cnt;
    dir = 1'b1;
    sendBit(1'b0, 1);
    sendBit(1'b1, 1);
    sendBit(1'b1, 1);
    sendBit(1'b0, 1);
    sendBit(1'b1, 1);
    checkOutput("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_data", 32'(data), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_pulses", 32'((valid_cnt - v0) + (ferr_cnt - f0)), 32'd0);
    v0 = valid_cnt;
    applyStimulus(8'h3C, 1'b1, 1'b1, 1);
    @(negedge clk);
    checkOutput("after_rst_valid", 32'(valid_cnt - v0), 32'd1);
    checkOutput("after_rst_data", 32'(data), 32'h3C);

    $display("[TB] back-to-back frames, bit_en every 4th cycle");
    v0 = valid_cnt; f0 = ferr_cnt;
    applyStimulus(8'hA5, 1'b1, 1'b1, 4);
    checkOutput("b2b_first_valid", 32'(valid_cnt - v0), 32'd1);
    checkOutput("b2b_first_data", 32'(data), 32'hA5);
    applyStimulus(8'h0F, 1'b1, 1'b1, 4);
    @(negedge clk);
    checkOutput("b2b_total_valid", 32'(valid_cnt - v0), 32'd2);
    checkOutput("b2b_ferr", 32'(ferr_cnt - f0), 32'd0);
    checkOutput("b2b_second_data", 32'(data), 32'h0F);
    checkOutput("b2b_busy", 32'(busy), 32'h0);

    checkOutput("pulse_overlap", 32'(overlap_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
